// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the memory-side bus arbiter.
// Write-buffer entries are packed as {addr, data, be}.
package bus_arbiter_pkg;

  localparam int LINE_W     = 256;
  localparam int WB_ENTRY_W = 68;
  localparam int OFFSET_W   = 5;

  localparam int ADDR_HI = 67;
  localparam int ADDR_LO = 36;
  localparam int DATA_HI = 35;
  localparam int DATA_LO = 4;
  localparam int BE_HI   = 3;

  typedef enum logic [2:0] {
    IDLE,
    IC_RD,
    DC_RD,
    WB_WR,
    DONE
  } state_e;

  typedef enum logic {
    IC,
    DATA
  } grant_e;

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter serialising icache refills, dcache refills and write-buffer
// drains onto a single main-memory port. The write buffer always drains before a dcache refill.
module bus_arbiter
  import bus_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_req_in,
  input  logic [31:0]       icache_addr_in,
  output logic              icache_ready_out,
  output logic [LINE_W-1:0] icache_rdata_out,
  input  logic              dcache_req_in,
  input  logic [31:0]       dcache_addr_in,
  output logic              dcache_ready_out,
  output logic [LINE_W-1:0] dcache_rdata_out,
  input  logic                  wb_empty_in,
  input  logic [WB_ENTRY_W-1:0] wb_data_in,
  output logic                  wb_pop_en_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [31:0]       mem_addr_out,
  output logic [31:0]       mem_wdata_out,
  output logic [3:0]        mem_be_out,
  input  logic              mem_ack_in,
  input  logic [LINE_W-1:0] mem_rdata_in
);

  state_e      state_q, state_d;
  grant_e      last_grant_q, last_grant_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;

  logic data_want;
  logic grant_ic;

  // Line offset bits are discarded on refill addresses.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{icache_addr_in[OFFSET_W-1:0], dcache_addr_in[OFFSET_W-1:0]};

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    mem_req_d        = mem_req_q;
    mem_we_d         = mem_we_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    mem_be_d         = mem_be_q;
    icache_ready_out = 1'b0;
    dcache_ready_out = 1'b0;
    wb_pop_en_out    = 1'b0;
    icache_rdata_out = '0;
    dcache_rdata_out = '0;

    data_want = !wb_empty_in || dcache_req_in;
    // On contention the icache wins only if the data side was served last.
    grant_ic  = icache_req_in && (!data_want || (last_grant_q == DATA));

    case (state_q)
      IDLE: begin
        if (grant_ic) begin
          state_d      = IC_RD;
          last_grant_d = IC;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = {icache_addr_in[31:OFFSET_W], {OFFSET_W{1'b0}}};
          mem_wdata_d  = '0;
          mem_be_d     = '0;
        end else if (data_want) begin
          last_grant_d = DATA;
          mem_req_d    = 1'b1;
          if (!wb_empty_in) begin
            state_d     = WB_WR;
            mem_we_d    = 1'b1;
            mem_addr_d  = wb_data_in[ADDR_HI:ADDR_LO];
            mem_wdata_d = wb_data_in[DATA_HI:DATA_LO];
            mem_be_d    = wb_data_in[BE_HI:0];
          end else begin
            state_d     = DC_RD;
            mem_we_d    = 1'b0;
            mem_addr_d  = {dcache_addr_in[31:OFFSET_W], {OFFSET_W{1'b0}}};
            mem_wdata_d = '0;
            mem_be_d    = '0;
          end
        end
      end

      IC_RD, DC_RD, WB_WR: begin
        if (mem_ack_in) begin
          icache_ready_out = (state_q == IC_RD);
          dcache_ready_out = (state_q == DC_RD);
          wb_pop_en_out    = (state_q == WB_WR);
          if (state_q == IC_RD) icache_rdata_out = mem_rdata_in;
          if (state_q == DC_RD) dcache_rdata_out = mem_rdata_in;
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_be_d    = '0;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset clears the latched address/data/be too, so the memory port never shows stale values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= DATA;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
    end
  end

  assign mem_req_out   = mem_req_q;
  assign mem_we_out    = mem_we_q;
  assign mem_addr_out  = mem_addr_q;
  assign mem_wdata_out = mem_wdata_q;
  assign mem_be_out    = mem_be_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected transactions,
// a negedge monitor pops and compares on every ready/pop pulse.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int K_IC = 0;
  localparam int K_DC = 1;
  localparam int K_WB = 2;

  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic         we;
    logic [31:0]  wdata;
    logic [3:0]   be;
    logic [255:0] line;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         icache_req_in, dcache_req_in, wb_empty_in, mem_ack_in;
  logic [31:0]  icache_addr_in, dcache_addr_in;
  logic [67:0]  wb_data_in;
  logic [255:0] mem_rdata_in;
  logic         icache_ready_out, dcache_ready_out, wb_pop_en_out;
  logic [255:0] icache_rdata_out, dcache_rdata_out;
  logic         mem_req_out, mem_we_out;
  logic [31:0]  mem_addr_out, mem_wdata_out;
  logic [3:0]   mem_be_out;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bus_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .icache_req_in    (icache_req_in),
    .icache_addr_in   (icache_addr_in),
    .icache_ready_out (icache_ready_out),
    .icache_rdata_out (icache_rdata_out),
    .dcache_req_in    (dcache_req_in),
    .dcache_addr_in   (dcache_addr_in),
    .dcache_ready_out (dcache_ready_out),
    .dcache_rdata_out (dcache_rdata_out),
    .wb_empty_in      (wb_empty_in),
    .wb_data_in       (wb_data_in),
    .wb_pop_en_out    (wb_pop_en_out),
    .mem_req_out      (mem_req_out),
    .mem_we_out       (mem_we_out),
    .mem_addr_out     (mem_addr_out),
    .mem_wdata_out    (mem_wdata_out),
    .mem_be_out       (mem_be_out),
    .mem_ack_in       (mem_ack_in),
    .mem_rdata_in     (mem_rdata_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_ctl"}, 256'({mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_be_out,
                                icache_ready_out, dcache_ready_out, wb_pop_en_out}), 256'(0));
    check({name, "_rdata"}, icache_rdata_out | dcache_rdata_out, 256'(0));
  endtask

  task automatic push(input int kind, input logic [31:0] addr, input logic we,
                      input logic [31:0] wdata, input logic [3:0] be, input logic [255:0] line);
    exp_t e;
    e.kind = kind; e.addr = addr; e.we = we; e.wdata = wdata; e.be = be; e.line = line;
    exp_q.push_back(e);
  endtask

  // Memory model: waits for a request, holds ack off for 'delay' cycles, then acks once.
  task automatic serve(input int delay, input logic [255:0] line);
    int          n;
    logic [31:0] a, wd;
    logic        w;
    logic [3:0]  b;
    n = 0;
    while (!mem_req_out && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("grant_seen", 256'(mem_req_out), 256'(1));
    a = mem_addr_out; w = mem_we_out; wd = mem_wdata_out; b = mem_be_out;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      check("hold_stable", 256'({mem_req_out, mem_addr_out, mem_we_out, mem_wdata_out, mem_be_out}),
            256'({1'b1, a, w, wd, b}));
    end
    mem_ack_in   = 1'b1;
    mem_rdata_in = line;
    @(posedge clk); #1;
    mem_ack_in   = 1'b0;
    mem_rdata_in = '0;
    check("done_req_low", 256'(mem_req_out), 256'(0));
  endtask

  // Monitor: every completion pulse must match the oldest expected transaction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (icache_ready_out || dcache_ready_out || wb_pop_en_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 256'({icache_ready_out, dcache_ready_out, wb_pop_en_out}), 256'(0));
        end else begin
          exp_t e;
          int   act_kind;
          e = exp_q.pop_front();
          act_kind = icache_ready_out ? K_IC : (dcache_ready_out ? K_DC : K_WB);
          check("pulse_onehot", 256'($countones({icache_ready_out, dcache_ready_out, wb_pop_en_out})), 256'(1));
          check("pulse_kind", 256'(act_kind), 256'(e.kind));
          check("mem_addr", 256'(mem_addr_out), 256'(e.addr));
          check("mem_we", 256'(mem_we_out), 256'(e.we));
          if (e.we) begin
            check("mem_wdata", 256'(mem_wdata_out), 256'(e.wdata));
            check("mem_be", 256'(mem_be_out), 256'(e.be));
            check("wb_rdata_zero", icache_rdata_out | dcache_rdata_out, 256'(0));
          end else if (e.kind == K_IC) begin
            check("icache_rdata", icache_rdata_out, e.line);
            check("dcache_rdata_idle", dcache_rdata_out, 256'(0));
          end else begin
            check("dcache_rdata", dcache_rdata_out, e.line);
            check("icache_rdata_idle", icache_rdata_out, 256'(0));
          end
        end
      end else begin
        check("rdata_gated", icache_rdata_out | dcache_rdata_out, 256'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset_outputs");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [255:0] l0, l1, l2, l3, l4;
    l0 = {8{32'hA5A5_A5A5}};
    l1 = {8{32'h1111_2222}};
    l2 = {8{32'h3C3C_0F0F}};
    l3 = {4{64'h0123_4567_89AB_CDEF}};
    l4 = {8{32'hFEED_F00D}};

    icache_req_in = 0; dcache_req_in = 0; wb_empty_in = 1; mem_ack_in = 0;
    icache_addr_in = '0; dcache_addr_in = '0; wb_data_in = '0; mem_rdata_in = '0;
    do_reset();
    check_quiet("idle_after_reset");

    // Plain dcache refill, offset bits cleared.
    dcache_req_in = 1; dcache_addr_in = 32'h0000_1234;
    push(K_DC, 32'h0000_1220, 1'b0, 32'h0, 4'h0, l0);
    serve(0, l0);
    dcache_req_in = 0;

    // Write buffer drains before the simultaneous dcache refill.
    wb_empty_in = 0; wb_data_in = {32'h0000_0040, 32'hDEAD_BEEF, 4'b0011};
    dcache_req_in = 1; dcache_addr_in = 32'h0000_0040;
    push(K_WB, 32'h0000_0040, 1'b1, 32'hDEAD_BEEF, 4'b0011, 256'(0));
    serve(0, l1);
    wb_empty_in = 1; wb_data_in = '0;
    push(K_DC, 32'h0000_0040, 1'b0, 32'h0, 4'h0, l2);
    serve(2, l2);
    dcache_req_in = 0;

    // Round robin from reset: IC, DATA, IC, DATA.
    do_reset();
    icache_req_in = 1; icache_addr_in = 32'h1000_0013;
    dcache_req_in = 1; dcache_addr_in = 32'h2000_0044;
    push(K_IC, 32'h1000_0000, 1'b0, 32'h0, 4'h0, l0);
    push(K_DC, 32'h2000_0040, 1'b0, 32'h0, 4'h0, l1);
    push(K_IC, 32'h1000_0000, 1'b0, 32'h0, 4'h0, l2);
    push(K_DC, 32'h2000_0040, 1'b0, 32'h0, 4'h0, l3);
    serve(1, l0);
    serve(1, l1);
    serve(1, l2);
    serve(1, l3);
    icache_req_in = 0; dcache_req_in = 0;

    // Long ack latency: outputs must stay frozen.
    icache_req_in = 1; icache_addr_in = 32'h3000_007F;
    push(K_IC, 32'h3000_0060, 1'b0, 32'h0, 4'h0, l4);
    serve(7, l4);
    icache_req_in = 0;
    @(posedge clk); #1;

    // Async reset in the middle of DC_RD, even with ack present.
    dcache_req_in = 1; dcache_addr_in = 32'h5555_5555;
    begin
      int n;
      n = 0;
      while (!mem_req_out && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("pre_reset_grant", 256'({mem_req_out, mem_addr_out}), 256'({1'b1, 32'h5555_5540}));
    end
    @(posedge clk); #1;
    rst_n = 0; mem_ack_in = 1; mem_rdata_in = l3;
    #1;
    check_quiet("mid_txn_reset");
    @(posedge clk); #1;
    check_quiet("mid_txn_reset_held");
    rst_n = 1; mem_ack_in = 0; mem_rdata_in = '0;
    push(K_DC, 32'h5555_5540, 1'b0, 32'h0, 4'h0, l1);
    serve(0, l1);
    dcache_req_in = 0;
    @(posedge clk); #1;

    // Spurious ack in IDLE is ignored.
    mem_ack_in = 1; mem_rdata_in = l2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_quiet("spurious_ack");
      check("spurious_state", 256'(dut.state_q), 256'(IDLE));
    end
    mem_ack_in = 0; mem_rdata_in = '0;

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Single-master memory-side arbiter between the instruction cache refill port, the data cache refill port and the data cache write buffer.
- Serialises all traffic onto one main-memory port.
- Refills are one 256-bit line transaction. Write-buffer drains are one 32-bit word with byte enables.
- Sits directly downstream of the data cache and instruction cache. Drives the caches' `arb_ready`/line-data and write-buffer pop inputs.

Parameters:
- LINE_W, 256, refill line width in bits
- WB_ENTRY_W, 68, write-buffer entry width {addr[67:36], data[35:4], be[3:0]}
- OFFSET_W, 5, line offset bits forced to zero on refill addresses

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- icache_req_in  in  1  icache refill request, level, held until ready
- icache_addr_in  in  32  icache miss address
- icache_ready_out  out  1  one-cycle refill-complete pulse
- icache_rdata_out  out  256  refill line, valid when icache_ready_out=1
- dcache_req_in  in  1  dcache refill request, level, held until ready
- dcache_addr_in  in  32  dcache miss address
- dcache_ready_out  out  1  one-cycle refill-complete pulse
- dcache_rdata_out  out  256  refill line, valid when dcache_ready_out=1
- wb_empty_in  in  1  write buffer empty
- wb_data_in  in  68  write-buffer head entry
- wb_pop_en_out  out  1  one-cycle pop of write-buffer head
- mem_req_out  out  1  memory request, held until mem_ack_in
- mem_we_out  out  1  1=word write, 0=line read
- mem_addr_out  out  32  memory address
- mem_wdata_out  out  32  write word
- mem_be_out  out  4  write byte enables
- mem_ack_in  in  1  one-cycle completion; mem_rdata_in valid same cycle on reads
- mem_rdata_in  in  256  read line

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- States: IDLE, IC_RD, DC_RD, WB_WR, DONE.
- Reset forces IDLE, last_grant=DATA, and all outputs 0, including the latched address, data and be registers.
- IDLE grant decision, evaluated every IDLE cycle:
  - Data side wants service when !wb_empty_in || dcache_req_in.
  - If both icache and the data side want service, grant the side not equal to last_grant (round-robin). Otherwise grant the sole requester.
  - A data-side grant goes to WB_WR if !wb_empty_in, else DC_RD. The write buffer always drains fully before any dcache refill, which guarantees read-after-write order.
  - With no requester, stay in IDLE.
- On grant, register in the same edge:
  - mem_req_out=1.
  - mem_we_out=1 for WB_WR, else 0.
  - mem_addr_out: for IC_RD/DC_RD, {req_addr[31:5],5'b0}; for WB_WR, wb_data_in[67:36].
  - mem_wdata_out=wb_data_in[35:4] and mem_be_out=wb_data_in[3:0] for WB_WR.
  - last_grant updated (IC or DATA).
- In IC_RD/DC_RD/WB_WR, hold all mem_* outputs stable until mem_ack_in. Request inputs are not resampled.
- Completion, combinational on mem_ack_in in the active state:
  - IC_RD: icache_ready_out=1, icache_rdata_out=mem_rdata_in.
  - DC_RD: dcache_ready_out=1, dcache_rdata_out=mem_rdata_in.
  - WB_WR: wb_pop_en_out=1.
  - Exactly one pulse per transaction. Next edge: mem_req_out=0, go to DONE.
- rdata outputs are 0 whenever their ready is 0.
- DONE lasts exactly one cycle with no grant. It lets the served cache drop its request, so a stale request is never re-granted. DONE then goes to IDLE.
- Minimum transaction length is grant edge → ack cycle → DONE → IDLE, so there is 1 idle turnaround cycle between transactions.
- mem_ack_in outside an active state is ignored.
- A requester deasserting before ready is illegal; the arbiter still completes the transaction.
- Async reset mid-transaction abandons it immediately: no pop, no ready. The memory model is reset by the same rst_n.

Decomposition:
- Shared package holds:
  - state enum: IDLE, IC_RD, DC_RD, WB_WR, DONE
  - grant encoding: IC, DATA
  - write-buffer field offsets: ADDR_HI=67, ADDR_LO=36, DATA_HI=35, DATA_LO=4, BE_HI=3
  - LINE_W and OFFSET_W constants
- Single flat module. No sub-module is warranted.

Test Plan:
- dcache_req=1, addr=0x0000_1234, wb empty → mem_addr_out=0x0000_1220, mem_we_out=0. Ack with line 0xA5..A5 → dcache_ready_out pulse 1 cycle carrying that line. Next cycle DONE, mem_req_out=0.
- wb holds {0x0000_0040, 0xDEAD_BEEF, 4'b0011} and dcache_req=1 to 0x40 simultaneously → WB_WR first (mem_we_out=1, be=0011), wb_pop_en_out pulse on ack. DC_RD is issued only after wb_empty_in=1.
- icache_req and dcache_req held together for 4 transactions → grants alternate IC, DATA, IC, DATA, starting with IC after reset.
- mem_ack_in delayed 7 cycles → mem_addr/we/wdata/be stable for all 7 cycles, exactly one ready pulse.
- rst_n low for 1 cycle in the middle of DC_RD → all outputs 0 immediately, no ready or pop. Request still high after reset → re-granted cleanly from IDLE.
- Spurious mem_ack_in in IDLE with no requests → no ready, no pop, state stays IDLE.
